// File: rtl/calculadora_sequenciador.sv
// Run sequencer for the calculadora: issues n_ops opera pulses, then dumps x0..x31 over valid/ready.
// Optional macro CALC_SEQ_SKIP_X0_EN starts the dump at x1 (x0 is hardwired zero).
module calculadora_sequenciador #(
    parameter int unsigned W   = 32,
    parameter int unsigned GAP = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [7:0]   n_ops,
    output logic         busy,
    output logic         done,
    output logic         opera,
    output logic [4:0]   read,
    input  logic [W-1:0] data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [4:0]   out_idx,
    output logic [W-1:0] out_data
);

`ifdef CALC_SEQ_SKIP_X0_EN
    localparam logic [4:0] FIRST_IDX = 5'd1;
`else
    localparam logic [4:0] FIRST_IDX = 5'd0;
`endif

    localparam int unsigned GW       = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
    localparam logic [4:0] LAST_IDX  = 5'd31;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE,
        S_GAP,
        S_SET,
        S_CAP,
        S_OUT,
        S_FIN
    } state_t;

    state_t        state;
    logic [7:0]    ops_cnt;
    logic [7:0]    n_lat;
    logic [GW-1:0] gap_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            ops_cnt   <= '0;
            n_lat     <= '0;
            gap_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            opera     <= 1'b0;
            read      <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
        end else begin
            case (state)
                // done is still high on the first IDLE cycle after FIN; a start
                // seen then belongs to the finishing run and is dropped.
                S_IDLE: begin
                    done <= 1'b0;
                    if (start && !done) begin
                        n_lat   <= n_ops;
                        ops_cnt <= '0;
                        busy    <= 1'b1;
                        if (n_ops != 8'd0) begin
                            opera <= 1'b1;
                            state <= S_PULSE;
                        end else begin
                            read  <= FIRST_IDX;
                            state <= S_SET;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_PULSE: begin
                    opera   <= 1'b0;
                    ops_cnt <= ops_cnt + 8'd1;
                    gap_cnt <= '0;
                    state   <= S_GAP;
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        if (ops_cnt == n_lat) begin
                            read  <= FIRST_IDX;
                            state <= S_SET;
                        end else begin
                            opera <= 1'b1;
                            state <= S_PULSE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                S_SET: begin
                    state <= S_CAP;
                end
                S_CAP: begin
                    out_data  <= data;
                    out_idx   <= read;
                    out_valid <= 1'b1;
                    state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (read == LAST_IDX) begin
                            state <= S_FIN;
                        end else begin
                            read  <= read + 5'd1;
                            state <= S_CAP;
                        end
                    end
                end
                S_FIN: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calculadora_sequenciador.sv
// Self-checking bench: stub calculadora RF, table-driven and random runs against a word-list model.
module tb_calculadora_sequenciador;

    localparam int unsigned W   = 32;
    localparam int unsigned GAP = 1;
`ifdef CALC_SEQ_SKIP_X0_EN
    localparam int FIRST = 1;
`else
    localparam int FIRST = 0;
`endif
    localparam int NW = 32 - FIRST;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [7:0]   n_ops = 8'd0;
    logic         busy, done, opera, out_valid;
    logic         out_ready = 1'b0;
    logic [4:0]   read, out_idx;
    logic [W-1:0] data, out_data;

    int vectors = 0;
    int miscompares = 0;

    // Stub register file: RF[i] = i replicated in every byte.
    assign data = {3'b000, read, 3'b000, read, 3'b000, read, 3'b000, read};

    always #5 clock = ~clock;

    calculadora_sequenciador #(.W(W), .GAP(GAP)) dut (
        .clock(clock), .reset(reset), .start(start), .n_ops(n_ops),
        .busy(busy), .done(done), .opera(opera), .read(read), .data(data),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_data(out_data)
    );

    typedef struct {
        logic [7:0] n;
        int         mode;
        int         exp_p;
    } vec_t;

    function automatic logic [31:0] model_word(input int i);
        return 32'(i) * 32'h01010101;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_opera"}, opera, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_read"}, read, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_idx"}, out_idx, 0);
        check({tag, "_out_data"}, out_data, 0);
    endtask

    // mode 0: ready always high; 1: ready 50%; 2: ready 25%. Modes 1/2 also spray start while busy.
    task automatic do_run(input logic [7:0] n, input int mode, input int exp_p);
        int cyc, pulses, last_pulse, words, last_hs, e;
        int q[$];
        bit seen_valid, finished, prev_stall;
        logic [4:0]   prev_idx;
        logic [W-1:0] prev_data;
        cyc = 0; pulses = 0; last_pulse = 0; words = 0; last_hs = 0;
        seen_valid = 0; finished = 0; prev_stall = 0;
        prev_idx = '0; prev_data = '0;
        for (int i = FIRST; i < 32; i++) q.push_back(i);
        @(negedge clock);
        start = 1'b1; n_ops = n; out_ready = 1'b0;
        while (!finished && cyc < 4000) begin
            @(negedge clock);
            cyc++;
            start = (mode != 0) && ($urandom_range(0, 4) == 0);
            n_ops = 8'($urandom);
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = ($urandom_range(0, 3) == 0);
            endcase
            if (opera) begin
                if (pulses == 0) check("first_pulse_cycle", cyc, 1);
                else check("pulse_period", cyc - last_pulse, GAP + 1);
                check("opera_during_dump", seen_valid, 0);
                pulses++;
                last_pulse = cyc;
            end
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_idx", out_idx, prev_idx);
                check("stall_data", out_data, prev_data);
            end
            if (out_valid) begin
                seen_valid = 1;
                if (q.size() > 0) check("read_hold", read, q[0]);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("extra_word", words + 1, NW);
                else begin
                    e = q.pop_front();
                    check("out_idx", out_idx, e);
                    check("out_data", out_data, model_word(e));
                end
                words++;
                last_hs = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_idx = out_idx;
            prev_data = out_data;
            if (done) begin
                check("done_after_last_hs", cyc - last_hs, 2);
                check("busy_at_done", busy, 1);
                check("valid_at_done", out_valid, 0);
                check("word_count", words, NW);
                check("pulse_count", pulses, exp_p);
                check("queue_empty", q.size(), 0);
                finished = 1;
                start = 1'b1;
            end else begin
                check("busy_during_run", busy, 1);
            end
        end
        check("run_timeout", finished, 1);
        @(negedge clock);
        start = 1'b0; out_ready = 1'b0;
        check("busy_after_done", busy, 0);
        check("done_single", done, 0);
        @(negedge clock);
        check("no_restart_busy", busy, 0);
        check("no_restart_opera", opera, 0);
    endtask

    vec_t vecs[6];
    bit   found;

    initial begin
        vecs[0] = '{n: 8'd3,   mode: 0, exp_p: 3};
        vecs[1] = '{n: 8'd0,   mode: 0, exp_p: 0};
        vecs[2] = '{n: 8'd1,   mode: 1, exp_p: 1};
        vecs[3] = '{n: 8'd255, mode: 0, exp_p: 255};
        vecs[4] = '{n: 8'd7,   mode: 2, exp_p: 7};
        vecs[5] = '{n: 8'd2,   mode: 1, exp_p: 2};

        #1 check_zero("por");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            check("idle_busy", busy, 0);
            check("idle_opera", opera, 0);
        end

        for (int v = 0; v < 6; v++) do_run(vecs[v].n, vecs[v].mode, vecs[v].exp_p);

        for (int r = 0; r < 4; r++) begin
            logic [7:0] rn;
            rn = 8'($urandom_range(0, 20));
            do_run(rn, 1 + (r % 2), int'(rn));
        end

        // Backpressure at x7, then release and expect x8 two cycles later.
        @(negedge clock);
        start = 1'b1; n_ops = 8'd0; out_ready = 1'b1;
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clock);
            start = 1'b0;
            if (out_valid && out_idx == 5'd7) begin
                out_ready = 1'b0;
                found = 1;
            end
        end
        check("bp_reach_idx7", found, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("bp_valid", out_valid, 1);
            check("bp_idx", out_idx, 7);
            check("bp_data", out_data, model_word(7));
            check("bp_read", read, 7);
        end
        out_ready = 1'b1;
        @(negedge clock);
        check("bp_gap_valid", out_valid, 0);
        @(negedge clock);
        check("bp_next_valid", out_valid, 1);
        check("bp_next_idx", out_idx, 8);
        check("bp_next_data", out_data, model_word(8));
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clock);
            if (done) found = 1;
        end
        check("bp_done", found, 1);
        @(negedge clock);
        check("bp_busy_low", busy, 0);
        out_ready = 1'b0;

        // Asynchronous reset in the middle of a dump.
        @(negedge clock);
        start = 1'b1; n_ops = 8'd1;
        found = 0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clock);
            start = 1'b0;
            if (out_valid) found = 1;
        end
        check("dump_reached", found, 1);
        #1 reset = 1'b1;
        #1 check_zero("async_rst");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_zero("after_rst");

        // Reset landing inside a PULSE cycle of an n_ops=5 run.
        start = 1'b1; n_ops = 8'd5;
        found = 0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clock);
            start = 1'b0;
            if (opera) found = 1;
        end
        check("pulse_reached", found, 1);
        #1 reset = 1'b1;
        #1 check("pulse_rst_opera", opera, 0);
        check("pulse_rst_busy", busy, 0);
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("no_resume_busy", busy, 0);
            check("no_resume_opera", opera, 0);
        end
        do_run(8'd2, 0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/calculadora_sequenciador.md
Name: calculadora_sequenciador

Overview:
Hardware initiator for the calculadora datapath. On `start` it issues a programmed number of single-cycle `opera` pulses, stepping the calculadora through its instruction memory. It then sweeps the register-file read port over x0..x31 and streams each value out over a valid/ready interface. It sits between the calculadora and a host/checker, replacing bench-driven stepping and readout.

Parameters:
W, 32, data width; must match the calculadora's W
GAP, 1, idle cycles with opera=0 between consecutive opera pulses; legal range >=1

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  begin a run; sampled only in IDLE
n_ops  in  8  number of opera pulses; latched when start is accepted
busy  out  1  high from start acceptance until the cycle done is asserted, inclusive
done  out  1  one-cycle pulse when the dump completes
opera  out  1  to calculadora; one-cycle execute pulse
read  out  5  to calculadora; register index, driven from a flop
data  in  W  from calculadora; combinational RF[read]
out_valid  out  1  out_data/out_idx hold a valid word
out_ready  in  1  consumer accepts the word
out_idx  out  5  register index of out_data
out_data  out  W  captured RF value

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- On reset, all outputs go to 0 immediately (opera=0, read=0, busy=0, done=0, out_valid=0, out_idx=0, out_data=0), and the FSM goes to IDLE. All counters clear.
- FSM states: IDLE, PULSE, GAP, SET, CAP, OUT, FIN.
- IDLE: when start=1, latch n_ops and set busy=1.
  - n_ops!=0: go to PULSE.
  - n_ops==0: set read=first index, go to SET.
- PULSE: opera=1 for exactly this cycle. Increment ops_cnt. Go to GAP.
- GAP: opera=0 for GAP cycles.
  - Then, if ops_cnt==n_ops: read<=first index, go to SET.
  - Otherwise go to PULSE.
  - Pulse period is GAP+1 cycles.
- SET: one settle cycle. read is stable and the calculadora's last write is committed. Go to CAP.
- CAP: out_data<=data, out_idx<=read, out_valid<=1. Go to OUT.
- OUT: hold out_valid, out_data and out_idx stable until out_ready=1. On the handshake cycle:
  - read==31: out_valid<=0, go to FIN.
  - Otherwise: read<=read+1, out_valid<=0, go to CAP.
  - Steady-state throughput is one word per 2 cycles.
- FIN: done=1 for one cycle, busy=1. Next cycle goes to IDLE with busy=0.
- start is ignored in every state except IDLE. A start in the same cycle done is asserted is ignored.
- n_ops changes after acceptance have no effect.
- ops_cnt is 8 bits. n_ops=255 yields exactly 255 pulses, with no wrap.
- read never wraps; the sweep stops at 31.
- out_ready while out_valid=0 is ignored.
- Reset mid-run (including during a PULSE cycle) drops opera in the same instant. No partial dump resumes after reset.

Optional Feature:
CALC_SEQ_SKIP_X0_EN:
- Defined: the first index is 1 (x0 is hardwired zero and is skipped). The dump emits 31 words, idx 1..31.
- Undefined: the first index is 0, and the dump emits 32 words, idx 0..31.
- No other behaviour changes.

Test Plan:
- Reset: assert reset asynchronously between clock edges -> all outputs 0 before the next edge, FSM in IDLE. After release with start=0 for 10 cycles -> busy=0, opera=0.
- Stepping, GAP=1, n_ops=3, stub calculadora counts opera pulses -> opera high in exactly 3 single cycles, 2 cycles apart. Stub count=3. No opera after SET is entered.
- Dump, out_ready=1 constantly, stub RF[i]=i*32'h01010101 -> 32 handshakes with out_idx 0..31 in order and out_data=RF[i]. done pulses once, 2 cycles after the last handshake. busy falls the cycle after done. With the macro defined -> 31 words, idx 1..31.
- Backpressure: out_ready=0 for 5 cycles while out_idx=7 -> out_valid, out_idx=7, out_data=32'h07070707 and read=7 stay stable. Idx 8 appears 2 cycles after out_ready rises.
- n_ops=0 -> zero opera pulses, dump starts directly. Pulse start again while busy -> no restart, and ops/dump counts are unaffected.
- Reset asserted during a PULSE cycle of an n_ops=5 run -> opera=0 immediately, busy=0. A new start with n_ops=2 -> exactly 2 pulses and a full dump.
